pc_fetch_unit: RTL and testbench

//  Holds the program counter and drives the instruction-memory fetch port.

---
 rtl/pc_fetch_unit_pkg.sv | 18 +
 rtl/fetch_out_buf.sv | 56 +++++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OUT   = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-addressed memory: sequential fetch steps by one word.
    localparam int unsigned PC_INC = 1;

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - decode-facing {pc, instr} register with valid/ready hold and flush
module fetch_out_buf
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic [DATA_W-1:0] load_instr_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    // Flush wins over load and over a pending handshake.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            instr_d = load_instr_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch front end
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    input  logic              if_ready
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              run_q;
    logic              buf_load;
    logic              buf_flush;

    // run_q holds off the first request until the cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (run_q && imem_req_ready) begin
                    state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid) begin
                        state_d = ST_REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    state_d   = ST_REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + ADDR_W'(PC_INC);
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    assign imem_req_valid = run_q && (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;

    fetch_out_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (buf_load),
        .load_pc_i    (pc_q),
        .load_instr_i (imem_resp_data),
        .flush_i      (buf_flush),
        .ready_i      (if_ready),
        .valid_o      (if_valid),
        .pc_o         (if_pc),
        .instr_o      (if_instr)
    );

    // A redirect while stalled in REQ legitimately retargets the pending request.
    a_req_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req_valid && !imem_req_ready && !redirect_valid) |=> $stable(imem_req_addr));

    a_if_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (if_valid && !if_ready) |=> ($stable(if_pc) && $stable(if_instr)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        if_valid, if_ready;
    logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, if_pc, if_instr;

    logic        rst2_n, b_req_valid, b_resp_valid, b_if_valid;
    logic [31:0] b_req_addr, b_resp_data, b_if_pc, b_if_instr;

    int checks = 0;
    int errors = 0;
    int resp_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    pc_fetch_unit u_dut (
        .clk (clk), .rst_n (rst_n),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .imem_req_valid (imem_req_valid), .imem_req_addr (imem_req_addr),
        .imem_req_ready (imem_req_ready), .imem_resp_valid (imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid (if_valid), .if_pc (if_pc), .if_instr (if_instr), .if_ready (if_ready)
    );

    pc_fetch_unit #(.RESET_PC (32'hFFFF_FFFF)) u_dut_wrap (
        .clk (clk), .rst_n (rst2_n),
        .redirect_valid (1'b0), .redirect_pc (32'h0),
        .imem_req_valid (b_req_valid), .imem_req_addr (b_req_addr),
        .imem_req_ready (1'b1), .imem_resp_valid (b_resp_valid),
        .imem_resp_data (b_resp_data),
        .if_valid (b_if_valid), .if_pc (b_if_pc), .if_instr (b_if_instr), .if_ready (1'b1)
    );

    // imem model: one response per accepted request, resp_delay extra cycles
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            pend_cnt <= 0;
            pend_addr <= 32'h0;
        end else begin
            if (pend && pend_cnt == 0) pend <= 1'b0;
            else if (pend) pend_cnt <= pend_cnt - 1;
            if (imem_req_valid && imem_req_ready) begin
                pend <= 1'b1;
                pend_cnt <= resp_delay;
                pend_addr <= imem_req_addr;
            end
        end
    end
    assign imem_resp_valid = pend && (pend_cnt == 0);
    assign imem_resp_data  = mem_word(pend_addr);

    logic        pend_b;
    logic [31:0] pend_b_addr;
    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            pend_b <= 1'b0;
            pend_b_addr <= 32'h0;
        end else begin
            pend_b <= b_req_valid;
            pend_b_addr <= b_req_addr;
        end
    end
    assign b_resp_valid = pend_b;
    assign b_resp_data  = mem_word(pend_b_addr);

    int n_acc5 = 0;
    bit saw9 = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'd5) n_acc5 <= n_acc5 + 1;
            if (if_valid && if_ready && if_pc == 32'd9) saw9 <= 1'b1;
        end
    end

    task automatic wait_valid(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst2_n = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_data got %h/%h want 0/0", if_pc, if_instr); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", imem_req_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL release_req_valid got %b want 0", imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream;
        bit ok; int cyc;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok, cyc);
            checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got none want pc %0d", k); end
            checks++; if (if_pc !== 32'(k) || if_instr !== mem_word(32'(k))) begin errors++; $display("FAIL stream_data got %h/%h want %h/%h", if_pc, if_instr, 32'(k), mem_word(32'(k))); end
            checks++; if (cyc != ((k == 0) ? 2 : 3)) begin errors++; $display("FAIL stream_spacing got %0d want %0d", cyc, (k == 0) ? 2 : 3); end
        end
    endtask

    task automatic test_req_stall;
        bit ok; int cyc;
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'd4) begin errors++; $display("FAIL pre_stall got %b/%h want 1/4", ok, if_pc); end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd5) begin errors++; $display("FAIL req_hold got %b/%h want 1/5", imem_req_valid, imem_req_addr); end
        end
        imem_req_ready = 1'b1;
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'd5 || if_instr !== mem_word(32'd5)) begin errors++; $display("FAIL stall_deliver got %h/%h want 5/%h", if_pc, if_instr, mem_word(32'd5)); end
        checks++; if (n_acc5 != 1) begin errors++; $display("FAIL fetch5_count got %0d want 1", n_acc5); end
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'd6) begin errors++; $display("FAIL after_stall got %h want 6", if_pc); end
    endtask

    task automatic test_out_stall;
        bit ok; int cyc;
        @(posedge clk); #1 if_ready = 1'b0;
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'd7) begin errors++; $display("FAIL out_first got %h want 7", if_pc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'd7 || if_instr !== mem_word(32'd7)) begin errors++; $display("FAIL out_hold got %b/%h/%h want 1/7/%h", if_valid, if_pc, if_instr, mem_word(32'd7)); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL out_no_req got %b want 0", imem_req_valid); end
        end
        if_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd8) begin errors++; $display("FAIL out_release got %b/%h want 1/8", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait;
        bit ok; int cyc;
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'd8) begin errors++; $display("FAIL pre_redirect got %h want 8", if_pc); end
        resp_delay = 3;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd9) begin errors++; $display("FAIL req9 got %b/%h want 1/9", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0; resp_delay = 0;
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'h40 || if_instr !== mem_word(32'h40)) begin errors++; $display("FAIL redirect_target got %h/%h want 40/%h", if_pc, if_instr, mem_word(32'h40)); end
        checks++; if (saw9 !== 1'b0) begin errors++; $display("FAIL stale_dropped got %b want 0", saw9); end
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'h41) begin errors++; $display("FAIL redirect_next got %h want 41", if_pc); end
    endtask

    task automatic test_reset_mid_wait;
        bit ok; int cyc;
        resp_delay = 3;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids got %b/%b want 0/0", if_valid, imem_req_valid); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL midrst_data got %h/%h want 0/0", if_pc, if_instr); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want 0", imem_req_addr); end
        resp_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL midrst_first_req got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
        wait_valid(ok, cyc);
        checks++; if (!ok || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin errors++; $display("FAIL midrst_deliver got %h/%h want 0/%h", if_pc, if_instr, mem_word(32'h0)); end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [31:0] exp_pc;
        checks++; if (b_if_pc !== 32'h0 || b_req_valid !== 1'b0 || b_req_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_reset got %h/%b/%h want 0/0/ffffffff", b_if_pc, b_req_valid, b_req_addr); end
        rst2_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_pc = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (b_if_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++; if (!ok || b_if_pc !== exp_pc || b_if_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL wrap_seq got %b/%h/%h want 1/%h/%h", ok, b_if_pc, b_if_instr, exp_pc, mem_word(exp_pc)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_req_stall();
        test_out_stall();
        test_redirect_wait();
        test_reset_mid_wait();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
